// File: rtl/timing_sequencer_pkg.sv
// Shared constants for the timing sequencer: state/PHASE encoding, count and
// timing-bus widths, interrupt-cycle length, and the SC-to-T one-hot decode.
package timing_sequencer_pkg;

  localparam int SC_W     = 4;
  localparam int T_W      = 16;
  localparam int ST_W     = 3;
  localparam int INTR_LEN = 3;

  // State codes double as the PHASE output encoding.
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
  localparam logic [ST_W-1:0] ST_EXEC  = 3'd2;
  localparam logic [ST_W-1:0] ST_INTR  = 3'd3;
  localparam logic [ST_W-1:0] ST_HALT  = 3'd4;

  typedef logic [SC_W-1:0] sc_t;

  function automatic logic [T_W-1:0] sc_onehot(input sc_t sc);
    logic [T_W-1:0] v;
    v     = '0;
    v[sc] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/timing_sequencer_seq_count.sv
// Sequence counter for the timing sequencer: synchronous clear has priority
// over enable; asynchronous active-high reset.
module seq_count
  import timing_sequencer_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_clr,
  input  logic  i_en,
  output sc_t   o_cnt
);

  sc_t r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/timing_sequencer.sv
// Instruction-cycle timing sequencer (IDLE/FETCH/EXEC/INTR/HALT) driving the
// one-hot T bus. Define SEQ_INTR_EN to enable the interrupt-acknowledge path.
module timing_sequencer
  import timing_sequencer_pkg::*;
#(
  parameter int FETCH_CYC = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_done,
  input  logic        i_hlt,
  input  logic        i_irq,
  output logic [3:0]  o_sc,
  output logic [15:0] o_t,
  output logic [2:0]  o_phase,
  output logic        o_inta,
  output logic        o_err
);

  localparam sc_t FETCH_LAST = SC_W'(FETCH_CYC - 1);
  localparam sc_t INTR_LAST  = SC_W'(INTR_LEN - 1);
  localparam sc_t SC_MAX     = '1;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic            r_err;
  logic            w_err_set;
  logic            w_clr;
  logic            w_en;
  logic            w_irq_taken;
  sc_t             w_sc;

`ifdef SEQ_INTR_EN
  assign w_irq_taken = i_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = i_irq;
  assign w_irq_taken  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        w_clr = 1'b1;
        if (i_start) w_state_nxt = ST_FETCH;
      end
      // SC keeps counting across the FETCH->EXEC boundary.
      ST_FETCH: begin
        w_en = 1'b1;
        if (w_sc == FETCH_LAST) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_en = 1'b1;
        if (i_done) begin
          w_clr = 1'b1;
          if (i_hlt)            w_state_nxt = ST_HALT;
          else if (w_irq_taken) w_state_nxt = ST_INTR;
          else                  w_state_nxt = ST_FETCH;
        end else if (w_sc == SC_MAX) begin
          w_clr       = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_INTR: begin
        w_en = 1'b1;
        if (w_sc == INTR_LAST) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  seq_count u_seq_count (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_cnt (w_sc)
  );

  assign o_sc    = w_sc;
  assign o_phase = r_state;
  assign o_err   = r_err;
  assign o_t     = ((r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_INTR))
                   ? sc_onehot(w_sc) : '0;

`ifdef SEQ_INTR_EN
  assign o_inta = (r_state == ST_INTR) && (w_sc == INTR_LAST);
`else
  assign o_inta = 1'b0;
`endif

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer: directed scenarios plus a random
// run compared cycle by cycle against a behavioural model.
module tb_timing_sequencer;

  localparam int FETCH_CYC = 3;
`ifdef SEQ_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, done, hlt, irq;
  logic [3:0]  sc;
  logic [15:0] t;
  logic [2:0]  phase;
  logic        inta, err;

  int checks = 0;
  int errors = 0;

  // Model state: phase as 0..4 (IDLE, FETCH, EXEC, INTR, HALT), count, sticky error.
  int m_phase;
  int m_sc;
  bit m_err;

  always #5 clk = ~clk;

  timing_sequencer #(.FETCH_CYC(FETCH_CYC)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_done  (done),
    .i_hlt   (hlt),
    .i_irq   (irq),
    .o_sc    (sc),
    .o_t     (t),
    .o_phase (phase),
    .o_inta  (inta),
    .o_err   (err)
  );

  task automatic model_reset();
    m_phase = 0;
    m_sc    = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_phase == 0 || m_phase == 4) begin
      if (start) begin m_phase = 1; m_sc = 0; end
    end else if (m_phase == 1) begin
      if (m_sc == FETCH_CYC - 1) m_phase = 2;
      m_sc = m_sc + 1;
    end else if (m_phase == 2) begin
      if (done) begin
        m_sc    = 0;
        m_phase = hlt ? 4 : ((irq && INTR_EN) ? 3 : 1);
      end else if (m_sc == 15) begin
        m_sc = 0; m_err = 1'b1; m_phase = 1;
      end else begin
        m_sc = m_sc + 1;
      end
    end else begin
      if (m_sc == 2) begin m_phase = 1; m_sc = 0; end
      else m_sc = m_sc + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic go_exec();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (FETCH_CYC) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; done = 1'b0; hlt = 1'b0; irq = 1'b0;
    model_reset();
    #2;
    checks++; if (sc !== 4'd0)     begin errors++; $display("FAIL reset_sc got %0d exp 0", sc); end
    checks++; if (t !== 16'h0)     begin errors++; $display("FAIL reset_t got %h exp 0000", t); end
    checks++; if (phase !== 3'd0)  begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (inta !== 1'b0)   begin errors++; $display("FAIL reset_inta got %b exp 0", inta); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    tick();
    rst = 1'b0;
    done = 1'b1; hlt = 1'b1;
    repeat (3) tick();
    done = 1'b0; hlt = 1'b0;
    checks++; if (phase !== 3'd0)  begin errors++; $display("FAIL idle_hold_phase got %0d exp 0", phase); end
    checks++; if (t !== 16'h0)     begin errors++; $display("FAIL idle_hold_t got %h exp 0000", t); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_t;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_t = 16'h0001 << i;
      checks++; if (t !== exp_t) begin errors++; $display("FAIL basic_t[%0d] got %h exp %h", i, t, exp_t); end
      checks++; if (phase !== ((i < FETCH_CYC) ? 3'd1 : 3'd2))
        begin errors++; $display("FAIL basic_phase[%0d] got %0d exp %0d", i, phase, (i < FETCH_CYC) ? 1 : 2); end
      if (i == 4) done = 1'b1;
      tick();
    end
    done = 1'b0;
    checks++; if (sc !== 4'd0)    begin errors++; $display("FAIL basic_done_sc got %0d exp 0", sc); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL basic_done_phase got %0d exp 1", phase); end
    checks++; if (t !== 16'h0001) begin errors++; $display("FAIL basic_done_t got %h exp 0001", t); end
  endtask

  task automatic test_done_at_15();
    pulse_reset();
    go_exec();
    repeat (15 - FETCH_CYC) tick();
    checks++; if (sc !== 4'd15)   begin errors++; $display("FAIL d15_pre_sc got %0d exp 15", sc); end
    checks++; if (t !== 16'h8000) begin errors++; $display("FAIL d15_pre_t got %h exp 8000", t); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (sc !== 4'd0)    begin errors++; $display("FAIL d15_sc got %0d exp 0", sc); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL d15_phase got %0d exp 1", phase); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL d15_err got %b exp 0", err); end
  endtask

  task automatic test_timeout();
    repeat (15) tick();
    checks++; if (sc !== 4'd15)   begin errors++; $display("FAIL to_pre_sc got %0d exp 15", sc); end
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL to_pre_phase got %0d exp 2", phase); end
    tick();
    checks++; if (sc !== 4'd0)    begin errors++; $display("FAIL to_sc got %0d exp 0", sc); end
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL to_err got %b exp 1", err); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL to_phase got %0d exp 1", phase); end
    repeat (4) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL to_sticky_err got %b exp 1", err); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL to_next_phase got %0d exp 1", phase); end
  endtask

  task automatic test_reset_mid();
    repeat (5) tick();
    checks++; if (sc !== 4'd5)    begin errors++; $display("FAIL rm_pre_sc got %0d exp 5", sc); end
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL rm_pre_phase got %0d exp 2", phase); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (sc !== 4'd0)    begin errors++; $display("FAIL rm_sc got %0d exp 0", sc); end
    checks++; if (t !== 16'h0)    begin errors++; $display("FAIL rm_t got %h exp 0000", t); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rm_phase got %0d exp 0", phase); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL rm_err got %b exp 0", err); end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rm_nostart_phase got %0d exp 0", phase); end
  endtask

  task automatic test_halt();
    pulse_reset();
    go_exec();
    done = 1'b1; hlt = 1'b1; irq = 1'b1;
    tick();
    hlt = 1'b0; irq = 1'b0;
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL halt_phase got %0d exp 4", phase); end
    checks++; if (t !== 16'h0)    begin errors++; $display("FAIL halt_t got %h exp 0000", t); end
    tick();
    done = 1'b0;
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL halt_hold_phase got %0d exp 4", phase); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL halt_start_phase got %0d exp 1", phase); end
    checks++; if (sc !== 4'd0)    begin errors++; $display("FAIL halt_start_sc got %0d exp 0", sc); end
  endtask

  task automatic test_irq();
    pulse_reset();
    go_exec();
    done = 1'b1; irq = 1'b1; hlt = 1'b0;
    tick();
    done = 1'b0;
`ifdef SEQ_INTR_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (phase !== 3'd3) begin errors++; $display("FAIL irq_phase[%0d] got %0d exp 3", i, phase); end
      checks++; if (sc !== 4'(i))   begin errors++; $display("FAIL irq_sc[%0d] got %0d exp %0d", i, sc, i); end
      checks++; if (inta !== (i == 2)) begin errors++; $display("FAIL irq_inta[%0d] got %b exp %b", i, inta, i == 2); end
      tick();
    end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL irq_after_phase got %0d exp 1", phase); end
    checks++; if (sc !== 4'd0)    begin errors++; $display("FAIL irq_after_sc got %0d exp 0", sc); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (phase !== 3'd1) begin errors++; $display("FAIL noirq_phase[%0d] got %0d exp 1", i, phase); end
      checks++; if (inta !== 1'b0)  begin errors++; $display("FAIL noirq_inta[%0d] got %b exp 0", i, inta); end
      tick();
    end
`endif
    irq = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_t;
    bit          exp_inta;
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      done  = ($urandom_range(0, 9) == 0);
      hlt   = ($urandom_range(0, 3) == 0);
      irq   = $urandom_range(0, 1);
      if (rst) begin
        model_reset();
        #1;
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rnd_async_rst[%0d] phase got %0d exp 0", n, phase); end
      end
      tick();
      exp_t    = (m_phase >= 1 && m_phase <= 3) ? (16'h0001 << m_sc) : 16'h0000;
      exp_inta = (m_phase == 3) && (m_sc == 2);
      checks++; if (sc !== 4'(m_sc))      begin errors++; $display("FAIL rnd_sc[%0d] got %0d exp %0d", n, sc, m_sc); end
      checks++; if (phase !== 3'(m_phase)) begin errors++; $display("FAIL rnd_phase[%0d] got %0d exp %0d", n, phase, m_phase); end
      checks++; if (t !== exp_t)          begin errors++; $display("FAIL rnd_t[%0d] got %h exp %h", n, t, exp_t); end
      checks++; if (inta !== exp_inta)    begin errors++; $display("FAIL rnd_inta[%0d] got %b exp %b", n, inta, exp_inta); end
      checks++; if (err !== m_err)        begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", n, err, m_err); end
    end
    rst = 1'b0; start = 1'b0; done = 1'b0; hlt = 1'b0; irq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_done_at_15();
    test_timeout();
    test_reset_mid();
    test_halt();
    test_irq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter FETCH_CYC, default 3, number of fetch/decode cycles before execute (legal 2..4).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  leave IDLE or HALT and begin instruction fetch.
REQ-005 DONE  input  1  execute phase complete, from instruction decode logic.
REQ-006 HLT  input  1  halt request; sampled only together with DONE.
REQ-007 IRQ  input  1  interrupt request; level; sampled only together with DONE.
REQ-008 SC  output  4  sequence count.
REQ-009 T  output  16  one-hot timing signals T0..T15.
REQ-010 PHASE  output  3  encoded controller state.
REQ-011 INTA  output  1  interrupt acknowledge pulse.
REQ-012 ERR  output  1  sticky execute-timeout flag.

Function
REQ-013 States SHALL be IDLE, FETCH, EXEC, INTR, HALT.
REQ-014 IDLE/HALT: SC held 0; START=1 -> FETCH next cycle with SC=0.
REQ-015 FETCH: SC +1 per cycle; at SC==FETCH_CYC-1 -> EXEC next cycle, SC continues to FETCH_CYC (not cleared).
REQ-016 EXEC: SC +1 per cycle; DONE=1 -> SC=0 next cycle; next state per REQ-017.
REQ-017 DONE priority: HLT=1 -> HALT; else IRQ=1 -> INTR; else -> FETCH.
REQ-018 EXEC with SC==15 and DONE=0: SC wraps to 0, ERR set, next state FETCH.
REQ-019 DONE==1 with SC==15 in EXEC: normal DONE handling, ERR unchanged.
REQ-020 INTR: lasts exactly 3 cycles, SC 0,1,2; INTA=1 only during SC==2; then FETCH, SC=0.
REQ-021 DONE, HLT, IRQ SHALL be ignored outside EXEC; START ignored outside IDLE/HALT.
REQ-022 T SHALL be the one-hot decode of SC in FETCH/EXEC/INTR, all-zero in IDLE/HALT; combinational from registered SC/state, zero latency.
REQ-023 PHASE encoding: IDLE=0, FETCH=1, EXEC=2, INTR=3, HALT=4.
REQ-024 ERR cleared only by RST.

Reset
REQ-025 RST=1 SHALL immediately force state IDLE, SC=0, T=0, PHASE=0, INTA=0, ERR=0, including mid-instruction.
REQ-026 First state change after RST deassert requires START sampled on a rising CLK.

Configuration
REQ-027 Macro SEQ_INTR_EN defined: interrupt path per REQ-017/REQ-020 active.
REQ-028 Macro SEQ_INTR_EN undefined: IRQ port present but ignored, INTR unreachable, INTA tied 0; DONE with HLT=0 -> FETCH.

Structure
REQ-029 Shared package SHALL hold state encoding, PHASE constants, SC width (4), T width (16), INTR length (3).
REQ-030 Sub-module seq_count SHALL implement the 4-bit counter with synchronous clear, enable and async reset; controller drives clear/enable.

Verification
REQ-031 RST pulse mid-EXEC at SC=5 -> same-cycle SC=0, T=0, PHASE=0, ERR=0.
REQ-032 START, DONE at SC=4 (FETCH_CYC=3) -> T sequence 0x0001,0x0002,0x0004,0x0008,0x0010, then SC=0, PHASE=1.
REQ-033 EXEC, DONE never asserted -> SC reaches 15, next cycle SC=0, ERR=1, PHASE=1; ERR stays 1 through next instruction.
REQ-034 SEQ_INTR_EN defined, DONE with IRQ=1 and HLT=0 -> PHASE=3 for 3 cycles, INTA=1 only at SC=2, then PHASE=1.
REQ-035 DONE with HLT=1 and IRQ=1 -> PHASE=4, T=0; START -> PHASE=1, SC=0.
REQ-036 SEQ_INTR_EN undefined, DONE with IRQ=1 -> PHASE=1, INTA=0 throughout.
